sl_transmitter: RTL and testbench

SL_TRANSMITTER -- requirements
Module: sl_transmitter

---
 rtl/sl_transmitter.sv | 139 +++++++++++++
 tb/tb_sl_transmitter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sl_transmitter.sv
// Two-line pulse serial transmitter: sends a configurable-length word MSB first,
// one low pulse per bit on sl0 or sl1, with optional odd parity and an inter-word gap.
module sl_transmitter #(
  parameter logic [15:0] DEF_CONFIG = 16'h0020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wr_data_tx,
  input  logic        data_we_tx,
  input  logic [15:0] wr_config_tx,
  input  logic        config_we_tx,
  output logic        rd_status_tx,
  output logic [15:0] rd_config_tx,
  output logic        status_changed_tx,
  output logic        sl0,
  output logic        sl1,
  output logic [1:0]  fsm_state_o
);

  // Write strobes are single-cycle and have no ready: a strobe is taken only when
  // rd_status_tx is 0 in that cycle (config also needs 8<=L<=32), else it is dropped.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_SPACE = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] config_q, config_d;
  logic [31:0] data_q, data_d;
  logic        parity_q, parity_d;
  logic [6:0]  hcnt_q, hcnt_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        chg_q, chg_d;

  logic        idle;
  logic        cfg_ok;
  logic [15:0] cfg_eff;
  logic [31:0] len_mask;
  logic [4:0]  idx;
  logic        cur_bit;

  function automatic logic [6:0] half_m1(input logic [1:0] sel);
    logic [7:0] v;
    v = (8'd4 << sel) - 8'd1;
    return v[6:0];
  endfunction

  function automatic logic [6:0] gap_m1(input logic [1:0] sel);
    logic [7:0] v;
    v = (8'd16 << sel) - 8'd1;
    return v[6:0];
  endfunction

  assign idle    = (state_q == S_IDLE);
  assign cfg_ok  = config_we_tx && idle &&
                   (wr_config_tx[5:0] >= 6'd8) && (wr_config_tx[5:0] <= 6'd32);
  // A config written in the same cycle as the data word already governs that word.
  assign cfg_eff = cfg_ok ? wr_config_tx : config_q;

  assign len_mask = (cfg_eff[5:0] >= 6'd32) ? 32'hFFFF_FFFF
                                            : ((32'd1 << cfg_eff[5:0]) - 32'd1);

  // cnt_q counts bits still to send; with parity on, the last one is the parity bit.
  assign idx     = cnt_q[4:0] - 5'd1 - {4'd0, config_q[8]};
  assign cur_bit = (config_q[8] && (cnt_q == 6'd1)) ? parity_q : data_q[idx];

  always_comb begin
    state_d  = state_q;
    config_d = cfg_ok ? wr_config_tx : config_q;
    data_d   = data_q;
    parity_d = parity_q;
    hcnt_d   = hcnt_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (data_we_tx) begin
          state_d  = S_PULSE;
          data_d   = wr_data_tx;
          parity_d = ~(^(wr_data_tx & len_mask));
          hcnt_d   = half_m1(cfg_eff[7:6]);
          cnt_d    = cfg_eff[5:0] + {5'd0, cfg_eff[8]};
        end
      end
      S_PULSE: begin
        if (hcnt_q == 7'd0) begin
          state_d = S_SPACE;
          hcnt_d  = half_m1(config_q[7:6]);
        end else begin
          hcnt_d = hcnt_q - 7'd1;
        end
      end
      S_SPACE: begin
        if (hcnt_q != 7'd0) begin
          hcnt_d = hcnt_q - 7'd1;
        end else if (cnt_q == 6'd1) begin
          state_d = S_GAP;
          hcnt_d  = gap_m1(config_q[7:6]);
        end else begin
          state_d = S_PULSE;
          hcnt_d  = half_m1(config_q[7:6]);
          cnt_d   = cnt_q - 6'd1;
        end
      end
      default: begin
        if (hcnt_q == 7'd0) state_d = S_IDLE;
        else                hcnt_d  = hcnt_q - 7'd1;
      end
    endcase
    chg_d = (state_d != S_IDLE) != (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      config_q <= DEF_CONFIG;
      data_q   <= '0;
      parity_q <= 1'b0;
      hcnt_q   <= '0;
      cnt_q    <= '0;
      chg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      config_q <= config_d;
      data_q   <= data_d;
      parity_q <= parity_d;
      hcnt_q   <= hcnt_d;
      cnt_q    <= cnt_d;
      chg_q    <= chg_d;
    end
  end

  assign sl0               = !((state_q == S_PULSE) && !cur_bit);
  assign sl1               = !((state_q == S_PULSE) &&  cur_bit);
  assign rd_status_tx      = !idle;
  assign rd_config_tx      = config_q;
  assign status_changed_tx = chg_q;
  assign fsm_state_o       = state_q;

endmodule

// File: tb/tb_sl_transmitter.sv
// Directed bench for sl_transmitter: line pulse decoding against expected bit queues,
// busy length, status pulses, config acceptance and asynchronous reset mid-word.
module tb_sl_transmitter;

  logic        clk;
  logic        rst_n;
  logic [31:0] wr_data_tx;
  logic        data_we_tx;
  logic [15:0] wr_config_tx;
  logic        config_we_tx;
  logic        rd_status_tx;
  logic [15:0] rd_config_tx;
  logic        status_changed_tx;
  logic        sl0;
  logic        sl1;
  logic [1:0]  fsm_state_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [0:0] exp_q[$];

  sl_transmitter #(.DEF_CONFIG(16'h0020)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wr_data_tx        (wr_data_tx),
    .data_we_tx        (data_we_tx),
    .wr_config_tx      (wr_config_tx),
    .config_we_tx      (config_we_tx),
    .rd_status_tx      (rd_status_tx),
    .rd_config_tx      (rd_config_tx),
    .status_changed_tx (status_changed_tx),
    .sl0               (sl0),
    .sl1               (sl1),
    .fsm_state_o       (fsm_state_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cfg_write(input logic [15:0] cfg);
    @(negedge clk);
    wr_config_tx = cfg;
    config_we_tx = 1'b1;
    @(negedge clk);
    config_we_tx = 1'b0;
  endtask

  // Starts a word (optionally with a same-cycle config write) and decodes the lines.
  task automatic send(input string tag, input logic do_cfg, input logic [15:0] cfg,
                      input logic [31:0] data, input int nbits, input logic [31:0] bits,
                      input int h, input int busy_exp, input logic inject);
    int busy, chg, len, post, cyc;
    logic both, prev_low, low, done;
    exp_q.delete();
    for (int i = nbits - 1; i >= 0; i--) exp_q.push_back(bits[i]);
    @(negedge clk);
    wr_data_tx   = data;
    data_we_tx   = 1'b1;
    wr_config_tx = cfg;
    config_we_tx = do_cfg;
    @(negedge clk);
    data_we_tx   = 1'b0;
    config_we_tx = 1'b0;
    check($sformatf("%s_first_pulse", tag), {31'd0, sl0 & sl1}, 32'd0);
    busy = 0; chg = 0; len = 0; post = 0; cyc = 0;
    both = 1'b0; prev_low = 1'b0; done = 1'b0;
    while (!done && cyc < 3000) begin
      if (!sl0 && !sl1) both = 1'b1;
      low = !sl0 || !sl1;
      if (low && !prev_low) begin
        if (exp_q.size() == 0) check($sformatf("%s_extra_pulse", tag), 32'd1, 32'd0);
        else check($sformatf("%s_bit", tag), {31'd0, !sl1}, {31'd0, exp_q.pop_front()});
        len = 1;
      end else if (low) begin
        len++;
      end else if (prev_low) begin
        check($sformatf("%s_low_len", tag), len, h);
      end
      prev_low = low;
      if (rd_status_tx) busy++;
      if (status_changed_tx) chg++;
      if (inject && cyc == 20) begin
        wr_data_tx = 32'h3C;
        data_we_tx = 1'b1;
      end
      if (inject && cyc == 30) begin
        wr_config_tx = 16'h00C8;
        config_we_tx = 1'b1;
      end
      if (cyc == 21 || cyc == 31) begin
        data_we_tx   = 1'b0;
        config_we_tx = 1'b0;
      end
      if (!rd_status_tx && busy > 0) post++;
      if (post == 3) done = 1'b1;
      cyc++;
      @(negedge clk);
    end
    check($sformatf("%s_done", tag), {31'd0, done}, 32'd1);
    check($sformatf("%s_busy", tag), busy, busy_exp);
    check($sformatf("%s_status_pulses", tag), chg, 32'd2);
    check($sformatf("%s_both_low", tag), {31'd0, both}, 32'd0);
    check($sformatf("%s_bits_left", tag), exp_q.size(), 32'd0);
  endtask

  initial begin
    int cnt;
    logic seen_idle;
    rst_n        = 1'b0;
    wr_data_tx   = '0;
    data_we_tx   = 1'b0;
    wr_config_tx = '0;
    config_we_tx = 1'b0;
    #12;
    check("rst_sl0", {31'd0, sl0}, 32'd1);
    check("rst_sl1", {31'd0, sl1}, 32'd1);
    check("rst_status", {31'd0, rd_status_tx}, 32'd0);
    check("rst_chg", {31'd0, status_changed_tx}, 32'd0);
    check("rst_config", {16'd0, rd_config_tx}, 32'h0020);
    check("rst_fsm", {30'd0, fsm_state_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    cfg_write(16'h0005);
    check("cfg_len5_rejected", {16'd0, rd_config_tx}, 32'h0020);
    cfg_write(16'h0021);
    check("cfg_len33_rejected", {16'd0, rd_config_tx}, 32'h0020);
    cfg_write(16'h0008);
    check("cfg_0008", {16'd0, rd_config_tx}, 32'h0008);

    send("a5", 1'b0, 16'h0000, 32'hA5, 8, 32'hA5, 4, 80, 1'b0);

    cfg_write(16'h0108);
    check("cfg_0108", {16'd0, rd_config_tx}, 32'h0108);
    send("a5_par", 1'b0, 16'h0000, 32'hA5, 9, 32'h14B, 4, 88, 1'b0);

    cfg_write(16'h0008);
    send("busy_writes", 1'b0, 16'h0000, 32'hA5, 8, 32'hA5, 4, 80, 1'b1);
    check("cfg_busy_ignored", {16'd0, rd_config_tx}, 32'h0008);

    cfg_write(16'h010C);
    send("len12_par", 1'b0, 16'h0000, 32'hFFFF_F00F, 13, 32'h01F, 4, 120, 1'b0);

    send("same_cycle", 1'b1, 16'h00E0, 32'h8000_0000, 32, 32'h8000_0000, 32, 2176, 1'b0);
    check("cfg_00e0", {16'd0, rd_config_tx}, 32'h00E0);

    // asynchronous reset in the 10th clock of a word
    cfg_write(16'h0008);
    @(negedge clk);
    wr_data_tx = 32'hA5;
    data_we_tx = 1'b1;
    @(negedge clk);
    data_we_tx = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sl0", {31'd0, sl0}, 32'd1);
    check("mid_rst_sl1", {31'd0, sl1}, 32'd1);
    check("mid_rst_status", {31'd0, rd_status_tx}, 32'd0);
    check("mid_rst_chg", {31'd0, status_changed_tx}, 32'd0);
    check("mid_rst_config", {16'd0, rd_config_tx}, 32'h0020);
    check("mid_rst_fsm", {30'd0, fsm_state_o}, 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    wr_data_tx = 32'h1;
    data_we_tx = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_accept", {31'd0, rd_status_tx}, 32'd1);
    @(negedge clk);
    data_we_tx = 1'b0;
    check("post_rst_sl0", {31'd0, sl0}, 32'd0);
    check("post_rst_sl1", {31'd0, sl1}, 32'd1);
    cnt = 0;
    seen_idle = 1'b0;
    while (!seen_idle && cnt < 400) begin
      @(negedge clk);
      cnt++;
      if (!rd_status_tx) seen_idle = 1'b1;
    end
    check("post_rst_word_end", {31'd0, seen_idle}, 32'd1);
    check("post_rst_busy", cnt, 32'd272);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
